// File: rtl/spi_xfer_arbiter_pkg.sv
// rtl/spi_xfer_arbiter_pkg.sv - shared constants and FSM encoding for the SPI transfer arbiter
package spi_xfer_arbiter_pkg;

   localparam int SPI_CHAR_LEN_BITS = 5;
   localparam int SPI_MAX_CHAR      = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SETUP = 3'd2,
      ST_GO    = 3'd3,
      ST_WAIT  = 3'd4,
      ST_BUSY  = 3'd5,
      ST_HOLD  = 3'd6,
      ST_DONE  = 3'd7
   } xfer_state_e;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_rr_arb.sv
// rtl/spi_rr_arb.sv - round-robin picker: first active request after the last winner
module spi_rr_arb
   import spi_xfer_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            valid
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      // Offsets 1..NREQ visit every requester once, the previous winner last.
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last) + k) % NREQ);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - shares one spi_shift engine among NREQ requesters with framed slave select
module spi_xfer_arbiter
   import spi_xfer_arbiter_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int SS_NB  = 8,
   parameter int CS_DLY = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NREQ-1:0]                req,
   input  logic [32*NREQ-1:0]             req_data,
   input  logic [SPI_CHAR_LEN_BITS*NREQ-1:0] req_len,
   input  logic [SS_NB*NREQ-1:0]          req_ss,
   output logic [NREQ-1:0]                gnt,
   output logic [NREQ-1:0]                done,
   output logic [31:0]                    rdata,
   output logic [3:0]                     sh_latched,
   output logic [3:0]                     sh_byte_sel,
   output logic [31:0]                    sh_p_in,
   output logic [SPI_CHAR_LEN_BITS-1:0]   sh_len,
   output logic                           sh_go,
   input  logic                           sh_tip,
   input  logic [31:0]                    sh_p_out,
   output logic [SS_NB-1:0]               ss_pad_o
);

   localparam int IW = idx_width(NREQ);
   localparam int LW = SPI_CHAR_LEN_BITS;
   localparam logic [3:0] DLY_LOAD = (CS_DLY == 0) ? 4'd0 : 4'(CS_DLY - 1);

   xfer_state_e     state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic [IW-1:0]   last;
   logic [IW-1:0]   gnt_idx;
   logic [NREQ-1:0] win_oh;
   logic [IW-1:0]   win_idx;
   logic            win_valid;

   logic [31:0]     data_a [NREQ];
   logic [LW-1:0]   len_a  [NREQ];
   logic [SS_NB-1:0] ss_a  [NREQ];

   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         data_a[k] = req_data[32*k +: 32];
         len_a[k]  = req_len[LW*k +: LW];
         ss_a[k]   = req_ss[SS_NB*k +: SS_NB];
      end
   end

   spi_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req   (req),
      .last  (last),
      .gnt   (win_oh),
      .idx   (win_idx),
      .valid (win_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         last    <= IW'(NREQ - 1);
         gnt_idx <= '0;
         gnt     <= '0;
         rdata   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == ST_IDLE && win_valid) begin
            last    <= win_idx;
            gnt_idx <= win_idx;
            gnt     <= win_oh;
         end
         if (state == ST_DONE)
            gnt <= '0;
         if (state == ST_BUSY && !sh_tip)
            rdata <= sh_p_out;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE:  if (win_valid) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (CS_DLY == 0) begin
               state_nxt = ST_GO;
            end else begin
               state_nxt = ST_SETUP;
               cnt_nxt   = DLY_LOAD;
            end
         end
         ST_SETUP: begin
            if (cnt == 4'd0) state_nxt = ST_GO;
            else             cnt_nxt   = cnt - 4'd1;
         end
         ST_GO:    state_nxt = ST_WAIT;
         ST_WAIT:  if (sh_tip) state_nxt = ST_BUSY;
         ST_BUSY: begin
            if (!sh_tip) begin
               if (CS_DLY == 0) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_HOLD;
                  cnt_nxt   = DLY_LOAD;
               end
            end
         end
         ST_HOLD: begin
            if (cnt == 4'd0) state_nxt = ST_DONE;
            else             cnt_nxt   = cnt - 4'd1;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Engine-side and pad outputs are pure decodes of state and the latched grant.
   always_comb begin
      sh_latched  = 4'b0000;
      sh_byte_sel = 4'h0;
      sh_p_in     = '0;
      sh_len      = '0;
      sh_go       = 1'b0;
      ss_pad_o    = '1;
      done        = '0;
      if (state == ST_LOAD) begin
         sh_latched  = 4'b0001;
         sh_byte_sel = 4'hF;
         sh_p_in     = data_a[gnt_idx];
      end
      if (state != ST_IDLE)
         sh_len = len_a[gnt_idx];
      if (state == ST_GO)
         sh_go = 1'b1;
      if (state == ST_SETUP || state == ST_GO || state == ST_WAIT ||
          state == ST_BUSY  || state == ST_HOLD)
         ss_pad_o = ~ss_a[gnt_idx];
      if (state == ST_DONE)
         done = gnt;
   end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - directed bench for spi_xfer_arbiter with a behavioural shift engine
module tb_spi_xfer_arbiter;
   import spi_xfer_arbiter_pkg::*;

   localparam int NREQ  = 4;
   localparam int SS_NB = 8;
   localparam int LW    = SPI_CHAR_LEN_BITS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]       req = '0;
   logic [32*NREQ-1:0]    req_data = '0;
   logic [LW*NREQ-1:0]    req_len = '0;
   logic [SS_NB*NREQ-1:0] req_ss = '0;

   logic [NREQ-1:0]  gnt_w [2];
   logic [NREQ-1:0]  done_w [2];
   logic [31:0]      rdata_w [2];
   logic [3:0]       lat_w [2];
   logic [3:0]       bsel_w [2];
   logic [31:0]      pin_w [2];
   logic [LW-1:0]    len_w [2];
   logic             go_w [2];
   logic             tip_w [2];
   logic [31:0]      pout_w [2];
   logic [SS_NB-1:0] ss_w [2];

   spi_xfer_arbiter #(.NREQ(NREQ), .SS_NB(SS_NB), .CS_DLY(2)) u_dly2 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_len(req_len),
      .req_ss(req_ss), .gnt(gnt_w[0]), .done(done_w[0]), .rdata(rdata_w[0]),
      .sh_latched(lat_w[0]), .sh_byte_sel(bsel_w[0]), .sh_p_in(pin_w[0]),
      .sh_len(len_w[0]), .sh_go(go_w[0]), .sh_tip(tip_w[0]), .sh_p_out(pout_w[0]),
      .ss_pad_o(ss_w[0])
   );

   spi_xfer_arbiter #(.NREQ(NREQ), .SS_NB(SS_NB), .CS_DLY(0)) u_dly0 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_len(req_len),
      .req_ss(req_ss), .gnt(gnt_w[1]), .done(done_w[1]), .rdata(rdata_w[1]),
      .sh_latched(lat_w[1]), .sh_byte_sel(bsel_w[1]), .sh_p_in(pin_w[1]),
      .sh_len(len_w[1]), .sh_go(go_w[1]), .sh_tip(tip_w[1]), .sh_p_out(pout_w[1]),
      .ss_pad_o(ss_w[1])
   );

   // Engine model: tip stays high for one clk per bit, slave returns the inverted word.
   logic [31:0] shreg [2];
   logic [5:0]  bits [2];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            tip_w[i] <= 1'b0; bits[i] <= '0; shreg[i] <= '0; pout_w[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (lat_w[i][0]) shreg[i] <= pin_w[i];
            if (go_w[i]) begin
               tip_w[i] <= 1'b1;
               bits[i]  <= (len_w[i] == 0) ? 6'd32 : ({1'b0, len_w[i]} + 6'd1);
            end else if (tip_w[i]) begin
               bits[i] <= bits[i] - 6'd1;
               if (bits[i] == 6'd1) begin
                  tip_w[i]  <= 1'b0;
                  pout_w[i] <= ~shreg[i];
               end
            end
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int oh2i(input logic [3:0] v);
      for (int k = 0; k < 4; k++) if (v[k]) return k;
      return -1;
   endfunction

   int lat_n [2] = '{0, 0};
   logic [31:0] lat_pin [2];
   logic [3:0]  lat_bsel [2];
   int ss_n [2] = '{0, 0};
   logic [7:0] ss_v [2];
   int go_cyc [2] = '{0, 0};
   logic [LW-1:0] go_len [2];
   int go_tip_n [2] = '{0, 0};
   int fall_cyc [2] = '{0, 0};
   logic prev_tip [2] = '{1'b0, 1'b0};
   logic prev_done [2] = '{1'b0, 1'b0};
   int b2b_n [2] = '{0, 0};
   int done_n [2] = '{0, 0};
   logic [3:0] done_v [2];
   logic [3:0] done_gnt [2];
   logic [31:0] done_rd [2];
   int done_cyc [2] = '{0, 0};
   int dg_n [2] = '{0, 0};
   int ord [2][16];
   int ord_n [2] = '{0, 0};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (lat_w[i][0]) begin
            lat_n[i] <= lat_n[i] + 1; lat_pin[i] <= pin_w[i]; lat_bsel[i] <= bsel_w[i];
            if (prev_done[i]) b2b_n[i] <= b2b_n[i] + 1;
         end
         if (ss_w[i] != '1) begin ss_n[i] <= ss_n[i] + 1; ss_v[i] <= ss_w[i]; end
         if (go_w[i]) begin
            go_cyc[i] <= cyc; go_len[i] <= len_w[i];
            if (tip_w[i]) go_tip_n[i] <= go_tip_n[i] + 1;
         end
         if (prev_tip[i] && !tip_w[i]) fall_cyc[i] <= cyc;
         prev_tip[i]  <= tip_w[i];
         prev_done[i] <= |done_w[i];
         if (done_w[i] != '0) begin
            done_n[i] <= done_n[i] + 1; done_v[i] <= done_w[i]; done_gnt[i] <= gnt_w[i];
            done_rd[i] <= rdata_w[i]; done_cyc[i] <= cyc;
            if (done_w[i] != gnt_w[i]) dg_n[i] <= dg_n[i] + 1;
            if (ord_n[i] < 16) begin
               ord[i][ord_n[i]] <= oh2i(done_w[i]);
               ord_n[i] <= ord_n[i] + 1;
            end
         end
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = '0;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic set_bg();
      for (int k = 0; k < NREQ; k++) begin
         req_data[32*k +: 32] = 32'hC0DE_0000 | 32'(k);
         req_len[LW*k +: LW]  = LW'(k + 3);
         req_ss[SS_NB*k +: SS_NB] = 8'(1 << (k + 4));
      end
   endtask

   task automatic wait_done(input int d, input int base, input int budget);
      bit ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         tick(1);
         if (done_n[d] != base) ok = 1'b1;
      end
      chk("done_timeout", 32'(ok), 32'd1);
   endtask

   typedef struct {
      logic [3:0]  req;
      int          lane;
      logic [31:0] data;
      logic [4:0]  len;
      logic [7:0]  ss;
      logic [3:0]  e_gnt;
      logic [31:0] e_pin;
      logic [4:0]  e_len;
      logic [7:0]  e_ss;
      int          e_sscnt;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vt [5];
   int c0, l0, s0, b0, o0, g0;

   initial begin
      vt[0] = '{4'b0001, 0, 32'hA5A5_0F0F, 5'd7,  8'h01, 4'b0001, 32'hA5A5_0F0F, 5'd7,  8'hFE, 14, 32'h5A5A_F0F0};
      vt[1] = '{4'b0010, 1, 32'h1234_5678, 5'd15, 8'h02, 4'b0010, 32'h1234_5678, 5'd15, 8'hFD, 22, 32'hEDCB_A987};
      vt[2] = '{4'b1000, 3, 32'hDEAD_BEEF, 5'd0,  8'h80, 4'b1000, 32'hDEAD_BEEF, 5'd0,  8'h7F, 38, 32'h2152_4110};
      vt[3] = '{4'b0101, 2, 32'h0BAD_F00D, 5'd1,  8'h04, 4'b0001, 32'hC0DE_0000, 5'd3,  8'hEF, 10, 32'h3F21_FFFF};
      vt[4] = '{4'b0110, 2, 32'h0BAD_F00D, 5'd1,  8'h04, 4'b0010, 32'hC0DE_0001, 5'd4,  8'hDF, 11, 32'h3F21_FFFE};

      tick(1);
      chk("rst_gnt",   32'(gnt_w[0]), 32'h0);
      chk("rst_done",  32'(done_w[0]), 32'h0);
      chk("rst_rdata", rdata_w[0], 32'h0);
      chk("rst_lat",   32'(lat_w[0]), 32'h0);
      chk("rst_bsel",  32'(bsel_w[0]), 32'h0);
      chk("rst_pin",   pin_w[0], 32'h0);
      chk("rst_len",   32'(len_w[0]), 32'h0);
      chk("rst_go",    32'(go_w[0]), 32'h0);
      chk("rst_ss",    32'(ss_w[0]), 32'hFF);
      rst_n = 1'b1;
      tick(2);

      for (int v = 0; v < 5; v++) begin
         set_bg();
         req_data[32*vt[v].lane +: 32]       = vt[v].data;
         req_len[LW*vt[v].lane +: LW]        = vt[v].len;
         req_ss[SS_NB*vt[v].lane +: SS_NB]   = vt[v].ss;
         c0 = cyc; l0 = lat_n[0]; s0 = ss_n[0]; b0 = done_n[0];
         req = vt[v].req;
         wait_done(0, b0, 200);
         req = '0;
         chk($sformatf("v%0d_lat_cnt", v), 32'(lat_n[0] - l0), 32'd1);
         chk($sformatf("v%0d_p_in", v), lat_pin[0], vt[v].e_pin);
         chk($sformatf("v%0d_bsel", v), 32'(lat_bsel[0]), 32'hF);
         chk($sformatf("v%0d_go_cyc", v), 32'(go_cyc[0] - c0), 32'd4);
         chk($sformatf("v%0d_len", v), 32'(go_len[0]), 32'(vt[v].e_len));
         chk($sformatf("v%0d_ss", v), 32'(ss_v[0]), 32'(vt[v].e_ss));
         chk($sformatf("v%0d_ss_cnt", v), 32'(ss_n[0] - s0), 32'(vt[v].e_sscnt));
         chk($sformatf("v%0d_done", v), 32'(done_v[0]), 32'(vt[v].e_gnt));
         chk($sformatf("v%0d_gnt", v), 32'(done_gnt[0]), 32'(vt[v].e_gnt));
         chk($sformatf("v%0d_rdata", v), done_rd[0], vt[v].e_rd);
         chk($sformatf("v%0d_hold_lat", v), 32'(done_cyc[0] - fall_cyc[0]), 32'd3);
         chk($sformatf("v%0d_rdata_held", v), rdata_w[0], vt[v].e_rd);
         tick(3);
      end

      // Contention: all four held high, grants must rotate.
      do_reset();
      set_bg();
      o0 = ord_n[0]; g0 = dg_n[0];
      req = 4'hF;
      for (int k = 0; k < 5; k++) wait_done(0, done_n[0], 300);
      req = '0;
      for (int k = 0; k < 5; k++)
         chk($sformatf("rr_order%0d", k), 32'(ord[0][o0 + k]), 32'(k % 4));
      chk("rr_done_eq_gnt", 32'(dg_n[0] - g0), 32'd0);
      chk("rr_idle_gap", 32'(b2b_n[0]), 32'd0);
      tick(60);

      // Zero setup/hold instance.
      do_reset();
      set_bg();
      req_data[31:0] = 32'hA5A5_0F0F; req_len[LW-1:0] = 5'd7; req_ss[7:0] = 8'h01;
      c0 = cyc; s0 = ss_n[1]; b0 = done_n[1];
      req = 4'b0001;
      wait_done(1, b0, 200);
      req = '0;
      chk("cs0_go_cyc", 32'(go_cyc[1] - c0), 32'd2);
      chk("cs0_done_lat", 32'(done_cyc[1] - fall_cyc[1]), 32'd1);
      chk("cs0_ss_cnt", 32'(ss_n[1] - s0), 32'd10);
      chk("cs0_rdata", done_rd[1], 32'h5A5A_F0F0);
      chk("cs0_done", 32'(done_v[1]), 32'h1);
      tick(60);

      // Requester 2 drops req during SETUP.
      do_reset();
      set_bg();
      l0 = lat_n[0]; b0 = done_n[0];
      req = 4'b0100;
      tick(2);
      req = '0;
      wait_done(0, b0, 200);
      chk("drop_done", 32'(done_v[0]), 32'h4);
      chk("drop_rdata", done_rd[0], 32'h3F21_FFFD);
      tick(10);
      chk("drop_no_regrant", 32'(lat_n[0] - l0), 32'd1);
      chk("drop_gnt_clear", 32'(gnt_w[0]), 32'h0);

      // Asynchronous reset in BUSY.
      do_reset();
      set_bg();
      b0 = done_n[0];
      req = 4'b0001;
      begin
         bit seen = 1'b0;
         for (int c = 0; c < 50 && !seen; c++) begin
            tick(1);
            if (tip_w[0]) seen = 1'b1;
         end
         chk("ar_tip_timeout", 32'(seen), 32'd1);
      end
      tick(2);
      rst_n = 1'b0;
      req = '0;
      #1;
      chk("ar_ss_off", 32'(ss_w[0]), 32'hFF);
      chk("ar_gnt_off", 32'(gnt_w[0]), 32'h0);
      tick(3);
      rst_n = 1'b1;
      tick(1);
      chk("ar_no_done", 32'(done_n[0] - b0), 32'd0);
      b0 = done_n[0];
      req = 4'b0101;
      wait_done(0, b0, 200);
      req = '0;
      chk("ar_restart_req0", 32'(done_v[0]), 32'h1);
      chk("go_tip_overlap", 32'(go_tip_n[0] + go_tip_n[1]), 32'd0);
      tick(60);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
